// File: rtl/readout_pkg.sv
// Shared definitions for the readout sequencer: state encoding, command
// word field positions and counter widths.
package readout_pkg;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_HDR_REQ   = 4'd1,
    ST_HDR_WAIT  = 4'd2,
    ST_ACQ_REQ   = 4'd3,
    ST_ACQ_WAIT  = 4'd4,
    ST_DATA_REQ  = 4'd5,
    ST_DATA_WAIT = 4'd6,
    ST_GAP       = 4'd7,
    ST_TRL_REQ   = 4'd8,
    ST_TRL_WAIT  = 4'd9
  } state_t;

  localparam int unsigned NSAMP_MSB = 23;
  localparam int unsigned NSAMP_LSB = 16;
  localparam int unsigned DEV_MSB   = 10;
  localparam int unsigned DEV_LSB   = 8;
  localparam int unsigned OP_MSB    = 7;
  localparam int unsigned OP_LSB    = 4;

  localparam int unsigned GAP_W  = 20;
  localparam int unsigned WDOG_W = 32;
  localparam int unsigned IDX_W  = 9;

  // Sample count is NSAMP+1, so a zero field still yields one sample (1..256).
  function automatic logic [IDX_W-1:0] nsamp(input logic [31:0] cmd);
    return IDX_W'(cmd[NSAMP_MSB:NSAMP_LSB]) + IDX_W'(1);
  endfunction

endpackage

// File: rtl/readout_sequencer_seq_timer.sv
// Loadable down-counter with a zero flag; holds at zero until reloaded.
module seq_timer
  import readout_pkg::*;
#(
  parameter int unsigned W = GAP_W
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/readout_sequencer.sv
// Readout transaction controller: header, N acquire/send cycles, trailer.
// Optional watchdog compiled in with `define READOUT_TIMEOUT_EN.
module readout_sequencer
  import readout_pkg::*;
#(
  parameter int unsigned SAMPLE_GAP     = 1000,
  parameter int unsigned TIMEOUT_CYCLES = 50000000
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [31:0]      CMD_IN,
  output logic             RDY,
  output logic [31:0]      CMD_Q,
  output logic             ACQ_START,
  input  logic             ACQ_DONE,
  output logic             SEND_HEADER,
  output logic             SEND_DATA,
  output logic             SEND_TRAILER,
  input  logic             BUSY,
  output logic             DONE,
  output logic             ERROR,
  output logic [IDX_W-1:0] SAMPLE_IDX
);

  if (SAMPLE_GAP >= (1 << GAP_W) || TIMEOUT_CYCLES == 0) begin : g_bad_cfg
    $error("readout_sequencer: parameter out of range");
  end

  state_t           state, state_next;
  logic [31:0]      cmd_q;
  logic [IDX_W-1:0] n_q, idx_q;
  logic             last_sample;
  logic             gap_zero;
  logic             wd_expire;

  assign last_sample = (idx_q == n_q - IDX_W'(1));

  seq_timer #(.W(GAP_W)) u_gap (
    .CLK      (CLK),
    .RST      (RST),
    .load     ((state == ST_DATA_WAIT) && (state_next == ST_GAP)),
    .load_val (GAP_W'(SAMPLE_GAP)),
    .en       (state == ST_GAP),
    .zero     (gap_zero)
  );

`ifdef READOUT_TIMEOUT_EN
  logic is_wait, wd_zero, error_q;

  assign is_wait = (state == ST_HDR_WAIT) || (state == ST_ACQ_WAIT) ||
                   (state == ST_DATA_WAIT) || (state == ST_TRL_WAIT);

  // Loaded with LIMIT-1 on entry so expiry lands on the LIMIT-th wait cycle.
  seq_timer #(.W(WDOG_W)) u_wdog (
    .CLK      (CLK),
    .RST      (RST),
    .load     (state_next != state),
    .load_val (WDOG_W'(TIMEOUT_CYCLES - 1)),
    .en       (is_wait),
    .zero     (wd_zero)
  );

  assign wd_expire = is_wait && wd_zero;

  always_ff @(posedge CLK) begin
    if (RST) begin
      error_q <= 1'b0;
    end else if ((state == ST_IDLE) && START) begin
      error_q <= 1'b0;
    end else if (wd_expire) begin
      error_q <= 1'b1;
    end
  end

  assign ERROR = error_q;
`else
  assign wd_expire = 1'b0;
  assign ERROR     = 1'b0;
`endif

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:      if (START) state_next = ST_HDR_REQ;
      ST_HDR_REQ:   state_next = ST_HDR_WAIT;
      ST_HDR_WAIT:  if (wd_expire) state_next = ST_TRL_REQ;
                    else if (!BUSY) state_next = ST_ACQ_REQ;
      ST_ACQ_REQ:   state_next = ST_ACQ_WAIT;
      ST_ACQ_WAIT:  if (wd_expire) state_next = ST_TRL_REQ;
                    else if (ACQ_DONE) state_next = ST_DATA_REQ;
      ST_DATA_REQ:  state_next = ST_DATA_WAIT;
      ST_DATA_WAIT: if (wd_expire) state_next = ST_TRL_REQ;
                    else if (!BUSY) state_next = last_sample ? ST_TRL_REQ : ST_GAP;
      ST_GAP:       if (gap_zero) state_next = ST_ACQ_REQ;
      ST_TRL_REQ:   state_next = ST_TRL_WAIT;
      ST_TRL_WAIT:  if (wd_expire || !BUSY) state_next = ST_IDLE;
      default:      state_next = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state        <= ST_IDLE;
      cmd_q        <= '0;
      n_q          <= '0;
      idx_q        <= '0;
      RDY          <= 1'b1;
      ACQ_START    <= 1'b0;
      SEND_HEADER  <= 1'b0;
      SEND_DATA    <= 1'b0;
      SEND_TRAILER <= 1'b0;
      DONE         <= 1'b0;
    end else begin
      state        <= state_next;
      RDY          <= (state_next == ST_IDLE);
      SEND_HEADER  <= (state_next == ST_HDR_REQ);
      ACQ_START    <= (state_next == ST_ACQ_REQ);
      SEND_DATA    <= (state_next == ST_DATA_REQ);
      SEND_TRAILER <= (state_next == ST_TRL_REQ);
      DONE         <= (state == ST_TRL_WAIT) && (state_next == ST_IDLE);
      if ((state == ST_IDLE) && START) begin
        cmd_q <= CMD_IN;
        n_q   <= nsamp(CMD_IN);
        idx_q <= '0;
      end else if ((state == ST_DATA_WAIT) && (state_next == ST_GAP)) begin
        idx_q <= idx_q + IDX_W'(1);
      end
    end
  end

  assign CMD_Q      = cmd_q;
  assign SAMPLE_IDX = idx_q;

endmodule
